quadrature_step_decoder: RTL and testbench

//  Upstream control stage for the n-bit up/down counter. Turns a 2-phase

---
 rtl/quadrature_step_decoder.sv | 121 ++++++++++++
 tb/tb_quadrature_step_decoder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/quadrature_step_decoder.sv
// quadrature_step_decoder
//   Front end for an n-bit up/down counter. Synchronises and glitch-filters a
//   quadrature encoder (A,B), emits one-cycle step pulses with a direction
//   level, flags and counts illegal Gray jumps, and registers load requests.
// Ports
//   Clock, Resetn       : rising-edge clock, synchronous active-low reset
//   A, B                : asynchronous encoder phases
//   ld_req, ld_val[n]   : load request and value (synchronous)
//   clr_err             : clear err / err_cnt
//   R[n], L             : registered load value / strobe to the counter
//   E, up_down          : one-cycle step pulse, direction (1 = up)
//   err, err_cnt[ERRW]  : sticky illegal flag, saturating illegal count
module quadrature_step_decoder #(
  parameter int unsigned n    = 2,
  parameter int unsigned FILT = 3,
  parameter int unsigned ERRW = 4
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic            A,
  input  logic            B,
  input  logic            ld_req,
  input  logic [n-1:0]    ld_val,
  input  logic            clr_err,
  output logic [n-1:0]    R,
  output logic            L,
  output logic            E,
  output logic            up_down,
  output logic            err,
  output logic [ERRW-1:0] err_cnt
);

  localparam int unsigned CW = (FILT < 2) ? 1 : $clog2(FILT + 1);
  localparam logic [CW-1:0]   FILT_MAX  = CW'(FILT);
  localparam logic [CW-1:0]   FILT_LAST = CW'(FILT - 1);
  localparam logic [ERRW-1:0] ERR_MAX   = {ERRW{1'b1}};

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_s1, r_s2, r_cand, r_filt;
  logic [CW-1:0] r_cnt;

  logic       w_change, w_qual, w_accept, w_decode, w_illegal, w_step, w_up;
  logic [1:0] w_val;

  // State register
  always_ff @(posedge Clock) begin
    if (!Resetn) r_state <= ST_INIT;
    else         r_state <= w_state_nxt;
  end

  // Next state plus accept/decode qualifiers
  always_comb begin
    w_state_nxt = r_state;
    w_change    = (r_s2 != r_cand);
    w_val       = w_change ? r_s2 : r_cand;
    // With FILT=1 a single sample is enough, so the change edge itself accepts.
    w_qual      = (!w_change && (r_cnt == FILT_LAST)) || ((FILT == 1) && w_change);
    w_accept    = w_qual && ((r_state == ST_INIT) || (w_val != r_filt));
    w_decode    = w_accept && (r_state == ST_RUN);
    w_illegal   = w_decode && ((r_filt ^ w_val) == 2'b11);
    w_step      = w_decode && !w_illegal;
    // Up sequence 00->01->11->10->00: successor of {a,b} is {b,~a}.
    w_up        = (w_val == {r_filt[0], ~r_filt[1]});
    if (r_state == ST_INIT && w_accept) w_state_nxt = ST_RUN;
  end

  // Synchroniser and glitch filter
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_s1   <= 2'b00;
      r_s2   <= 2'b00;
      r_cand <= 2'b00;
      r_filt <= 2'b00;
      r_cnt  <= '0;
    end else begin
      r_s1 <= {A, B};
      r_s2 <= r_s1;
      if (w_accept) begin
        r_filt <= w_val;
        r_cand <= w_val;
        r_cnt  <= '0;
      end else if (w_change) begin
        r_cand <= r_s2;
        r_cnt  <= CW'(1);
      end else if (r_state == ST_RUN && r_cand == r_filt) begin
        r_cnt  <= '0;
      end else if (r_cnt < FILT_MAX) begin
        r_cnt  <= r_cnt + CW'(1);
      end
    end
  end

  // Registered outputs; a coincident load suppresses the step pulse
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      R       <= '0;
      L       <= 1'b0;
      E       <= 1'b0;
      up_down <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      L <= ld_req;
      if (ld_req) R <= ld_val;
      E <= w_step && !ld_req;
      if (w_step) up_down <= w_up;
      if (w_illegal) begin
        err <= 1'b1;
        if (clr_err)                err_cnt <= ERRW'(1);
        else if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERRW'(1);
      end else if (clr_err) begin
        err     <= 1'b0;
        err_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_quadrature_step_decoder.sv
// Directed bench for quadrature_step_decoder (n=2, FILT=3, ERRW=4).
// Inputs change just after the falling edge; outputs are sampled there too.
module tb_quadrature_step_decoder;

  logic       Clock = 1'b0;
  logic       Resetn, A, B, ld_req, clr_err;
  logic [1:0] ld_val;
  logic [1:0] R;
  logic       L, E, up_down, err;
  logic [3:0] err_cnt;

  int total = 0;
  int bad   = 0;

  quadrature_step_decoder #(.n(2), .FILT(3), .ERRW(4)) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .A       (A),
    .B       (B),
    .ld_req  (ld_req),
    .ld_val  (ld_val),
    .clr_err (clr_err),
    .R       (R),
    .L       (L),
    .E       (E),
    .up_down (up_down),
    .err     (err),
    .err_cnt (err_cnt)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Drive AB for 'cycles' clocks; E must pulse only on sample 'pulse_at' (0 = never).
  task automatic hold_ab(input string tag, input logic [1:0] ab, input int cycles,
                         input int pulse_at, input logic dir);
    {A, B} = ab;
    for (int i = 1; i <= cycles; i++) begin
      @(negedge Clock);
      chk({tag, "_E"}, 32'(E), 32'(i == pulse_at));
      if (i == pulse_at) chk({tag, "_dir"}, 32'(up_down), 32'(dir));
    end
  endtask

  initial begin
    Resetn = 1'b0; A = 1'b1; B = 1'b1;
    ld_req = 1'b0; ld_val = 2'b00; clr_err = 1'b0;

    // 1: reset with AB=11, then INIT absorbs 11 silently
    @(negedge Clock);
    @(negedge Clock);
    chk("rst_R", 32'(R), 0);
    chk("rst_L", 32'(L), 0);
    chk("rst_E", 32'(E), 0);
    chk("rst_dir", 32'(up_down), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_errcnt", 32'(err_cnt), 0);
    Resetn = 1'b1;
    hold_ab("init11", 2'b11, 6, 0, 1'b0);
    chk("init11_err", 32'(err), 0);

    // Re-enter INIT at 00 so the up sequence starts from 00
    Resetn = 1'b0; {A, B} = 2'b00;
    @(negedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;
    hold_ab("init00", 2'b00, 8, 0, 1'b0);

    // 2: up sequence, pulse on the 5th sample after the change
    hold_ab("up01", 2'b01, 8, 5, 1'b1);
    hold_ab("up11", 2'b11, 8, 5, 1'b1);
    hold_ab("up10", 2'b10, 8, 5, 1'b1);
    hold_ab("up00", 2'b00, 8, 5, 1'b1);

    // 3: down sequence, direction held afterwards
    hold_ab("dn10", 2'b10, 8, 5, 1'b0);
    hold_ab("dn11", 2'b11, 8, 5, 1'b0);
    hold_ab("dn01", 2'b01, 8, 5, 1'b0);
    hold_ab("dnhold", 2'b01, 6, 0, 1'b0);
    chk("dnhold_dir", 32'(up_down), 0);

    // 4: back to 00, 2-cycle glitch rejected, then illegal jumps
    hold_ab("dn00", 2'b00, 8, 5, 1'b0);
    hold_ab("glitch", 2'b10, 2, 0, 1'b0);
    hold_ab("glitch_ret", 2'b00, 10, 0, 1'b0);
    chk("glitch_err", 32'(err), 0);
    hold_ab("ill11", 2'b11, 8, 0, 1'b0);
    chk("ill_err", 32'(err), 1);
    chk("ill_errcnt", 32'(err_cnt), 1);
    chk("ill_dir", 32'(up_down), 0);
    for (int j = 0; j < 20; j++) begin
      hold_ab("illrep", (j % 2 == 0) ? 2'b00 : 2'b11, 6, 0, 1'b0);
      if (j == 12) chk("ill_errcnt14", 32'(err_cnt), 14);
    end
    chk("sat_errcnt", 32'(err_cnt), 15);
    chk("sat_err", 32'(err), 1);

    // 5: load coincident with an up accept (11 -> 10)
    {A, B} = 2'b10; ld_val = 2'b10;
    for (int i = 1; i <= 5; i++) begin
      @(negedge Clock);
      if (i < 5) chk("ldacc_preE", 32'(E), 0);
      if (i == 4) ld_req = 1'b1;
      if (i == 5) begin
        chk("ldacc_L", 32'(L), 1);
        chk("ldacc_R", 32'(R), 2);
        chk("ldacc_E", 32'(E), 0);
        chk("ldacc_dir", 32'(up_down), 1);
        ld_req = 1'b0; ld_val = 2'b01;
      end
    end
    @(negedge Clock);
    chk("ldhold_L", 32'(L), 0);
    chk("ldhold_R", 32'(R), 2);
    chk("ldhold_E", 32'(E), 0);

    // clr_err coincident with an illegal accept (10 -> 01)
    {A, B} = 2'b01;
    for (int i = 1; i <= 5; i++) begin
      @(negedge Clock);
      if (i == 4) clr_err = 1'b1;
      if (i == 5) begin
        chk("clrill_err", 32'(err), 1);
        chk("clrill_errcnt", 32'(err_cnt), 1);
        chk("clrill_E", 32'(E), 0);
        clr_err = 1'b0;
      end
    end
    @(negedge Clock);
    clr_err = 1'b1;
    @(negedge Clock);
    clr_err = 1'b0;
    chk("clr_err", 32'(err), 0);
    chk("clr_errcnt", 32'(err_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
